// File: rtl/mdr_fifo.sv
// Multi-entry memory data register between instruction memory and fetch/decode.
// Registered-state handshakes, occupancy/almost-full reporting and branch-redirect flush.
module mdr_fifo #(
  parameter int DATA_W   = 68,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push, pop;

  // Handshake outputs depend on registered occupancy only, so a full buffer
  // refuses a write even when the head is being consumed in the same cycle.
  assign wr_ready    = (count_q != CNT_W'(DEPTH));
  assign rd_valid    = (count_q != '0);
  assign push        = wr_valid & wr_ready;
  assign pop         = rd_valid & rd_ready;
  assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; an empty buffer never exposes it.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mdr_fifo.sv
// Directed bench for mdr_fifo: a queue scoreboard holds the expected contents,
// and every cycle the DUT outputs are compared against it before the clock edge.
module tb_mdr_fifo;

  localparam int DATA_W   = 68;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              almost_full;

  logic [DATA_W-1:0] sb[$];
  int                n_assert;
  int                n_fail;

  mdr_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle, checks current outputs against the scoreboard, then
  // advances the scoreboard by what the edge should do.
  task automatic cyc(input logic wv, input logic [DATA_W-1:0] wd, input logic rr,
                     input logic fl, input logic rs);
    int  occ;
    logic do_push, do_pop;
    rst_n    = rs;
    flush    = fl;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
    occ = sb.size();
    chk("count",       DATA_W'(count),       DATA_W'(occ));
    chk("wr_ready",    DATA_W'(wr_ready),    DATA_W'(occ != DEPTH));
    chk("rd_valid",    DATA_W'(rd_valid),    DATA_W'(occ != 0));
    chk("almost_full", DATA_W'(almost_full), DATA_W'(occ >= AF_LEVEL));
    if (occ != 0) chk("rd_data", rd_data, sb[0]);
    else          chk("rd_data_empty", rd_data, '0);
    do_push = wv && (occ != DEPTH);
    do_pop  = rr && (occ != 0);
    if (!rs || fl) begin
      sb.delete();
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(wd);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"},    DATA_W'(count),       '0);
    chk({tag, "_rd_valid"}, DATA_W'(rd_valid),    '0);
    chk({tag, "_wr_ready"}, DATA_W'(wr_ready),    DATA_W'(1));
    chk({tag, "_rd_data"},  rd_data,              '0);
    chk({tag, "_af"},       DATA_W'(almost_full), '0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = DATA_W'(68'h5A5);
    rd_ready = 1'b0;

    // Reset held two cycles with a write pending
    repeat (2) @(posedge clk);
    #2;
    chk_empty("reset");

    // Fill to full, almost_full from 3
    cyc(1'b1, DATA_W'(1), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(2), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(3), 1'b0, 1'b0, 1'b1);
    chk("af_at_3", DATA_W'(almost_full), DATA_W'(1));
    cyc(1'b1, DATA_W'(4), 1'b0, 1'b0, 1'b1);
    chk("full_count",    DATA_W'(count),    DATA_W'(4));
    chk("full_wr_ready", DATA_W'(wr_ready), '0);
    // Fifth word refused
    cyc(1'b1, DATA_W'(15), 1'b0, 1'b0, 1'b1);
    chk("refused_count", DATA_W'(count), DATA_W'(4));
    // Full with both sides active: one pop only
    cyc(1'b1, DATA_W'(15), 1'b1, 1'b0, 1'b1);
    chk("full_pushpop_count", DATA_W'(count), DATA_W'(3));
    chk("full_pushpop_head",  rd_data,        DATA_W'(2));
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk_empty("drained");
    cyc(1'b1, DATA_W'(15), 1'b0, 1'b0, 1'b1);
    chk("late_accept", rd_data, DATA_W'(15));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Wrap-around at steady occupancy 2
    cyc(1'b1, DATA_W'(16), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(17), 1'b0, 1'b0, 1'b1);
    for (int i = 18; i < 26; i++) begin
      cyc(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b1);
      chk("wrap_count", DATA_W'(count), DATA_W'(2));
    end
    chk("wrap_head", rd_data, DATA_W'(24));
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Flush beats a simultaneous push and pop
    cyc(1'b1, DATA_W'(33), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(34), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(35), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(8'hAB), 1'b1, 1'b1, 1'b1);
    chk_empty("flush");
    cyc(1'b1, DATA_W'(8'hCD), 1'b0, 1'b0, 1'b1);
    chk("after_flush_head", rd_data, DATA_W'(8'hCD));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation overrides push and pop
    cyc(1'b1, {4'hA, 64'hDEAD_BEEF_0123_4567}, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, {4'h5, 64'hFEED_FACE_89AB_CDEF}, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(7), 1'b1, 1'b0, 1'b0);
    chk_empty("mid_reset");

    // Random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)),
          {4'($urandom), $urandom, $urandom},
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 49) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
